// File: rtl/gpio_debounce.sv
// Per-bit input conditioner: synchroniser chain, debounce counter, clean level and edge pulses.
// Define GPIO_DEBOUNCE_EVT_EN to add sticky per-bit event flags and an interrupt output.
module gpio_debounce #(
    parameter int unsigned Width          = 8,
    parameter int unsigned SyncStages     = 2,
    parameter int unsigned DebounceCycles = 50000
) (
    input  logic             clk_sys_i,
    input  logic             rst_sys_i,
    input  logic [Width-1:0] raw_i,
    output logic [Width-1:0] level_o,
    output logic [Width-1:0] rise_o,
    output logic [Width-1:0] fall_o,
    input  logic [Width-1:0] evt_clr_i,
    output logic [Width-1:0] evt_o,
    output logic             irq_o
);

    localparam int unsigned         CntWidth = $clog2(DebounceCycles + 1);
    localparam logic [CntWidth-1:0] CntLast  = CntWidth'(DebounceCycles - 1);

    logic [SyncStages-1:0][Width-1:0] sync_pipe;
    logic [Width-1:0]                 sync;
    logic [CntWidth-1:0]              cnt [Width];

    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            sync_pipe <= '0;
        end else begin
            sync_pipe[0] <= raw_i;
            for (int unsigned s = 1; s < SyncStages; s++) begin
                sync_pipe[s] <= sync_pipe[s-1];
            end
        end
    end

    assign sync = sync_pipe[SyncStages-1];

    // Counter holds how many consecutive cycles sync has disagreed with the accepted level.
    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            for (int unsigned b = 0; b < Width; b++) begin
                cnt[b] <= '0;
            end
            level_o <= '0;
            rise_o  <= '0;
            fall_o  <= '0;
        end else begin
            rise_o <= '0;
            fall_o <= '0;
            for (int unsigned b = 0; b < Width; b++) begin
                if (sync[b] == level_o[b]) begin
                    cnt[b] <= '0;
                end else if (cnt[b] == CntLast) begin
                    level_o[b] <= sync[b];
                    cnt[b]     <= '0;
                    rise_o[b]  <= sync[b];
                    fall_o[b]  <= ~sync[b];
                end else begin
                    cnt[b] <= cnt[b] + CntWidth'(1);
                end
            end
        end
    end

`ifdef GPIO_DEBOUNCE_EVT_EN
    logic [Width-1:0] evt;
    logic [Width-1:0] evt_next;
    logic             irq;

    // Set wins over clear: a pulse in the clearing cycle keeps the flag.
    always_comb begin
        evt_next = (evt & ~evt_clr_i) | rise_o | fall_o;
    end

    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            evt <= '0;
            irq <= 1'b0;
        end else begin
            evt <= evt_next;
            irq <= |evt_next;
        end
    end

    assign evt_o = evt;
    assign irq_o = irq;
`else
    logic unused_evt_clr;

    assign unused_evt_clr = ^evt_clr_i;
    assign evt_o          = '0;
    assign irq_o          = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_debounce.sv
// Scoreboard bench for gpio_debounce: window-based reference model feeds an expectation queue,
// a monitor pops and compares every cycle for a DebounceCycles=4 and a DebounceCycles=1 instance.
module tb_gpio_debounce;

    localparam int unsigned W    = 8;
    localparam int unsigned SYNC = 2;
    localparam int unsigned DB_A = 4;
    localparam int unsigned DB_B = 1;

    typedef struct packed {
        logic [W-1:0] level;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic [W-1:0] evt;
        logic         irq;
    } obs_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] raw = '0;
    logic [W-1:0] clr = '0;

    logic [W-1:0] level_a, rise_a, fall_a, evt_a;
    logic [W-1:0] level_b, rise_b, fall_b, evt_b;
    logic         irq_a, irq_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gpio_debounce #(.Width(W), .SyncStages(SYNC), .DebounceCycles(DB_A)) dut (
        .clk_sys_i(clk), .rst_sys_i(rst), .raw_i(raw),
        .level_o(level_a), .rise_o(rise_a), .fall_o(fall_a),
        .evt_clr_i(clr), .evt_o(evt_a), .irq_o(irq_a)
    );

    gpio_debounce #(.Width(W), .SyncStages(SYNC), .DebounceCycles(DB_B)) dut_d1 (
        .clk_sys_i(clk), .rst_sys_i(rst), .raw_i(raw),
        .level_o(level_b), .rise_o(rise_b), .fall_o(fall_b),
        .evt_clr_i(clr), .evt_o(evt_b), .irq_o(irq_b)
    );

    // Reference model: raw samples newest-first; sync seen at this edge is rawq[SYNC].
    logic [W-1:0] rawq [$];
    obs_t         exp_a [$];
    obs_t         exp_b [$];
    obs_t         m_a, m_b;

    // Bits whose last d synchronised samples all disagree with the current level.
    function automatic logic [W-1:0] accept_mask(input int unsigned d, input logic [W-1:0] lvl);
        logic [W-1:0] m;
        m = '1;
        for (int unsigned j = 0; j < d; j++) m &= rawq[SYNC + j] ^ lvl;
        return m;
    endfunction

    function automatic obs_t step(input obs_t cur, input int unsigned d);
        obs_t         nxt;
        logic [W-1:0] acc;
        nxt = '0;
`ifdef GPIO_DEBOUNCE_EVT_EN
        nxt.evt = (cur.evt & ~clr) | cur.rise | cur.fall;
        nxt.irq = |nxt.evt;
`endif
        acc       = accept_mask(d, cur.level);
        nxt.rise  = acc & ~cur.level;
        nxt.fall  = acc & cur.level;
        nxt.level = cur.level ^ acc;
        return nxt;
    endfunction

    initial begin
        m_a = '0;
        m_b = '0;
        forever begin
            @(posedge clk);
            if (rst) begin
                rawq = {};
                for (int i = 0; i < SYNC + DB_A; i++) rawq.push_back('0);
                m_a = '0;
                m_b = '0;
            end else begin
                rawq.push_front(raw);
                void'(rawq.pop_back());
                m_a = step(m_a, DB_A);
                m_b = step(m_b, DB_B);
            end
            exp_a.push_back(m_a);
            exp_b.push_back(m_b);
        end
    end

    task automatic check(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t: got level=%h rise=%h fall=%h evt=%h irq=%b, expected level=%h rise=%h fall=%h evt=%h irq=%b",
                     name, $time, act.level, act.rise, act.fall, act.evt, act.irq,
                     exp.level, exp.rise, exp.fall, exp.evt, exp.irq);
        end
    endtask

    // Monitor: outputs are presented every cycle, sampled 1 time unit after the edge.
    initial begin
        obs_t ea, eb;
        forever begin
            @(posedge clk);
            #1;
            if (exp_a.size() == 0 || exp_b.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_empty t=%0t: got queue sizes %0d/%0d, expected nonzero",
                         $time, exp_a.size(), exp_b.size());
            end else begin
                ea = exp_a.pop_front();
                eb = exp_b.pop_front();
                check("db4", {level_a, rise_a, fall_a, evt_a, irq_a}, ea);
                check("db1", {level_b, rise_b, fall_b, evt_b, irq_b}, eb);
            end
        end
    end

    task automatic hold(input logic [W-1:0] v, input int n);
        raw = v;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [W-1:0] cur;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Clean rising edge on bit 0, then release.
        hold(8'h00, 4);
        hold(8'h01, 10);
        hold(8'h00, 10);

        // Glitches on bit 3 shorter than the debounce window, then a real edge.
        repeat (10) begin
            hold(8'h08, 3);
            hold(8'h00, 3);
        end
        hold(8'h08, 10);
        hold(8'h00, 10);

        // Reset in the middle of a count.
        hold(8'hFF, 4);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        hold(8'hFF, 10);

        // Multi-bit rise and fall in the same cycle.
        hold(8'hA5, 10);
        hold(8'h5A, 10);

        // Single-bit MSB edge (three-edge latency on the DebounceCycles=1 instance).
        hold(8'h00, 10);
        hold(8'h80, 10);

        // Event flags: rise on bit 0, clear coinciding with the fall pulse, then clear again.
        hold(8'h00, 10);
        hold(8'h01, 10);
        raw = 8'h00;
        repeat (6) @(negedge clk);
        clr = 8'h01;
        repeat (2) @(negedge clk);
        clr = 8'h00;
        repeat (6) @(negedge clk);

        // Randomised toggling, clears and occasional resets.
        cur = raw;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                rst = 1'b0;
            end
            clr = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
            cur = cur ^ (W'($urandom) & W'($urandom));
            hold(cur, $urandom_range(1, 8));
        end
        clr = '0;
        hold(raw, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion by t=%0t, expected stimulus to finish", $time);
        $fatal(1);
    end

endmodule
